uart_transmitter_fifo: RTL

//  Parametrised UART transmitter: next generation of the single-byte TX.

---
 rtl/uart_transmitter_fifo_if.sv | 15 +
 rtl/uart_transmitter_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_fifo_if.sv
// Push-side bus of the FIFO-backed UART transmitter: word, push strobe, back-pressure and fill level.
interface uart_transmitter_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] dataIn;
    logic                  txStart;
    logic                  TxReady;
    logic [CW-1:0]         fifoCount;

    modport master (output dataIn, output txStart, input TxReady, input fifoCount);
    modport slave  (input dataIn, input txStart, output TxReady, output fifoCount);
endinterface

// File: rtl/uart_transmitter_fifo.sv
// UART transmitter with a TX FIFO, configurable word width, optional parity and 1/2 stop bits.
// Bit timing is OVERSAMPLE baudTick strobes per bit; frames are sent back to back while queued.
module uart_transmitter_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    baudTick,
    uart_transmitter_fifo_if.slave  bus,
    output logic                    tx,
    output logic                    txBusy,
    output logic                    txDone
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [2:0]            state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  ready, push, pop, fifo_empty, bit_end;
    logic [DATA_WIDTH-1:0] head;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    assign ready         = (count_q < CW'(FIFO_DEPTH));
    assign bus.TxReady   = ready;
    assign bus.fifoCount = count_q;
    assign push          = bus.txStart & ready;
    assign fifo_empty    = (count_q == '0);
    assign head          = mem_q[rd_ptr_q];
    assign bit_end       = baudTick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        if (state_q != S_IDLE && baudTick)
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        state_d   = (PARITY != 0) ? S_PAR : S_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        pop       = !fifo_empty;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A pop always launches a new frame, from IDLE or straight out of the last stop bit.
        if (pop) begin
            shift_d = head;
            par_d   = parity_of(head);
            state_d = S_START;
        end
    end

    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        if (push)
            mem_q[wr_ptr_q] <= bus.dataIn;
    end

    assign tx     = tx_q;
    assign txBusy = (state_q != S_IDLE);
    assign txDone = done_q;
endmodule
